dff_shiftreg_n: RTL and testbench

DFF_SHIFTREG_N -- requirements
Module: dff_shiftreg_n

---
 rtl/dff_shiftreg_n.sv | 112 +++++++++++
 tb/tb_dff_shiftreg_n.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dff_shiftreg_n.sv
// dff_shiftreg_n
//   Parameterised multi-stage register bank with a per-stage valid flag.
//   On each enabled clock edge the bank holds, shifts serial data in at
//   stage 0, parallel-loads every stage, or rotates by one stage. The
//   valid flags move with the data, so cnt always reports how many stages
//   hold a word.
//
// Ports
//   clk   in   single clock, all state changes on its rising edge
//   rst   in   synchronous active-high reset, overrides everything
//   clr   in   synchronous flush of data and valid, overrides en/mode
//   en    in   enable, 0 holds all state
//   mode  in   00 hold, 01 shift, 10 parallel load, 11 rotate
//   d     in   serial word entering stage 0 on a shift
//   pd    in   parallel load data, slice k feeds stage k
//   q     out  stage DEPTH-1 contents
//   pq    out  all stages, slice k is stage k
//   vld   out  per-stage valid, bit k is stage k
//   cnt   out  number of valid stages
//   full  out  cnt == DEPTH
//   empty out  cnt == 0
module dff_shiftreg_n #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       d,
  input  logic [WIDTH*DEPTH-1:0] pd,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH*DEPTH-1:0] pq,
  output logic [DEPTH-1:0]       vld,
  output logic [CW-1:0]          cnt,
  output logic                   full,
  output logic                   empty
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_ROT   = 2'b11;

  logic [WIDTH*DEPTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]       vld_q, vld_d;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + CW'(v[i]);
    end
    return acc;
  endfunction

  // Next-state: clr outranks the enable, which outranks the mode select.
  // Stage k occupies bits [WIDTH*(k+1)-1:WIDTH*k], so moving stage k to
  // k+1 is a left shift of the packed vector by one word.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr) begin
      data_d = '0;
      vld_d  = '0;
    end else if (en) begin
      case (mode)
        MODE_SHIFT: begin
          data_d = {data_q[WIDTH*(DEPTH-1)-1:0], d};
          vld_d  = {vld_q[DEPTH-2:0], 1'b1};
        end
        MODE_LOAD: begin
          data_d = pd;
          vld_d  = '1;
        end
        MODE_ROT: begin
          data_d = {data_q[WIDTH*(DEPTH-1)-1:0], data_q[WIDTH*DEPTH-1 -: WIDTH]};
          vld_d  = {vld_q[DEPTH-2:0], vld_q[DEPTH-1]};
        end
        MODE_HOLD: begin
          data_d = data_q;
          vld_d  = vld_q;
        end
        default: begin
          data_d = data_q;
          vld_d  = vld_q;
        end
      endcase
    end
  end

  // State register: rst wins over every other input on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign pq    = data_q;
  assign q     = data_q[WIDTH*DEPTH-1 -: WIDTH];
  assign vld   = vld_q;
  assign cnt   = popcount(vld_q);
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: tb/tb_dff_shiftreg_n.sv
// tb_dff_shiftreg_n
//   Directed scenarios for the documented WIDTH=8/DEPTH=4 cases followed by
//   randomized traffic, all compared against an array-based reference model
//   of the stage contents and their valid flags.
module tb_dff_shiftreg_n;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic           clk;
  logic           rst, clr, en;
  logic [1:0]     mode;
  logic [W-1:0]   d;
  logic [W*D-1:0] pd;
  logic [W-1:0]   q;
  logic [W*D-1:0] pq;
  logic [D-1:0]   vld;
  logic [CW-1:0]  cnt;
  logic           full, empty;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one word and one valid bit per stage.
  logic [W-1:0] m_word [D];
  logic         m_vld  [D];

  dff_shiftreg_n #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d), .pd(pd),
    .q(q), .pq(pq), .vld(vld), .cnt(cnt), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic e,
                            input logic [1:0] m, input logic [W-1:0] dd,
                            input logic [W*D-1:0] ppd);
    logic [W-1:0] tw [D];
    logic         tv [D];
    if (r || c) begin
      for (int k = 0; k < D; k++) begin
        m_word[k] = '0;
        m_vld[k]  = 1'b0;
      end
    end else if (e) begin
      for (int k = 0; k < D; k++) begin
        tw[k] = m_word[k];
        tv[k] = m_vld[k];
      end
      case (m)
        2'b01: begin
          // newest word enters stage 0, oldest falls off the top
          for (int k = 1; k < D; k++) begin
            m_word[k] = tw[k-1];
            m_vld[k]  = tv[k-1];
          end
          m_word[0] = dd;
          m_vld[0]  = 1'b1;
        end
        2'b10: begin
          for (int k = 0; k < D; k++) begin
            m_word[k] = ppd[W*k +: W];
            m_vld[k]  = 1'b1;
          end
        end
        2'b11: begin
          for (int k = 0; k < D; k++) begin
            m_word[(k + 1) % D] = tw[k];
            m_vld[(k + 1) % D]  = tv[k];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    logic [W*D-1:0] e_pq;
    logic [D-1:0]   e_vld;
    int             e_cnt;
    e_cnt = 0;
    for (int k = 0; k < D; k++) begin
      e_pq[W*k +: W] = m_word[k];
      e_vld[k]       = m_vld[k];
      if (m_vld[k]) e_cnt++;
    end
    chk({tag, "_pq"},    64'(pq),    64'(e_pq));
    chk({tag, "_q"},     64'(q),     64'(m_word[D-1]));
    chk({tag, "_vld"},   64'(vld),   64'(e_vld));
    chk({tag, "_cnt"},   64'(cnt),   64'(e_cnt));
    chk({tag, "_full"},  64'(full),  64'(e_cnt == D));
    chk({tag, "_empty"}, 64'(empty), 64'(e_cnt == 0));
  endtask

  // Apply inputs, take one rising edge, then compare just after it.
  task automatic step(input string tag, input logic r, input logic c, input logic e,
                      input logic [1:0] m, input logic [W-1:0] dd,
                      input logic [W*D-1:0] ppd);
    rst = r; clr = c; en = e; mode = m; d = dd; pd = ppd;
    @(posedge clk);
    model_edge(r, c, e, m, dd, ppd);
    #1;
    check_model(tag);
    // Scramble inputs between edges; the next step overwrites them before
    // the following edge, so state must not react to these values.
    d = W'($urandom);
    pd = (W*D)'($urandom);
    mode = 2'($urandom);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00; d = '0; pd = '0;
    for (int k = 0; k < D; k++) begin
      m_word[k] = '0;
      m_vld[k]  = 1'b0;
    end
    @(negedge clk);

    // Reset state
    step("rst", 1, 0, 1, 2'b10, 8'h00, 32'hFFFF_FFFF);
    chk("rst_pq_const", 64'(pq), 64'h0);
    chk("rst_empty_const", 64'(empty), 64'h1);

    // Four shifts fill the bank, a fifth discards the oldest word
    step("sh1", 0, 0, 1, 2'b01, 8'h11, '0);
    step("sh2", 0, 0, 1, 2'b01, 8'h22, '0);
    step("sh3", 0, 0, 1, 2'b01, 8'h33, '0);
    step("sh4", 0, 0, 1, 2'b01, 8'h44, '0);
    chk("fill_pq_const", 64'(pq), 64'h1122_3344);
    chk("fill_q_const", 64'(q), 64'h11);
    chk("fill_full_const", 64'(full), 64'h1);
    step("sh5", 0, 0, 1, 2'b01, 8'h55, '0);
    chk("ovf_pq_const", 64'(pq), 64'h2233_4455);
    chk("ovf_q_const", 64'(q), 64'h22);

    // Enable low holds regardless of mode
    for (int i = 0; i < 3; i++) step("hold_en0", 0, 0, 0, 2'b01, 8'hAA, '0);
    chk("hold_pq_const", 64'(pq), 64'h2233_4455);
    step("hold_mode0", 0, 0, 1, 2'b00, 8'hAA, 32'h1234_5678);

    // Parallel load then rotate
    step("load", 0, 0, 1, 2'b10, 8'h00, 32'hDEAD_BEEF);
    chk("load_q_const", 64'(q), 64'hDE);
    step("rot", 0, 0, 1, 2'b11, 8'h00, '0);
    chk("rot_pq_const", 64'(pq), 64'hADBE_EFDE);
    chk("rot_q_const", 64'(q), 64'hAD);

    // Partially filled bank rotates its valid flags too
    step("rst2", 1, 0, 0, 2'b00, 8'h00, '0);
    step("psh1", 0, 0, 1, 2'b01, 8'hA1, '0);
    step("psh2", 0, 0, 1, 2'b01, 8'hB2, '0);
    chk("part_vld_const", 64'(vld), 64'h3);
    step("prot", 0, 0, 1, 2'b11, 8'h00, '0);
    chk("prot_vld_const", 64'(vld), 64'h6);
    chk("prot_cnt_const", 64'(cnt), 64'h2);
    step("prot_wrap1", 0, 0, 1, 2'b11, 8'h00, '0);
    step("prot_wrap2", 0, 0, 1, 2'b11, 8'h00, '0);

    // clr with en low, clr over a load, then rst over a load
    step("clr_en0", 0, 1, 0, 2'b01, 8'h77, '0);
    chk("clr_pq_const", 64'(pq), 64'h0);
    step("reload", 0, 0, 1, 2'b10, 8'h00, 32'h0102_0304);
    step("clr_vs_load", 0, 1, 1, 2'b10, 8'h00, 32'hFFFF_FFFF);
    step("reload2", 0, 0, 1, 2'b10, 8'h00, 32'hCAFE_F00D);
    step("rst_vs_load", 1, 0, 1, 2'b10, 8'h00, 32'hFFFF_FFFF);
    chk("rstwin_vld_const", 64'(vld), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, c, e;
      r = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 4) != 0);
      step("rnd", r, c, e, 2'($urandom), W'($urandom), (W*D)'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
